mips_regfile: RTL and testbench



---
 rtl/mips_pkg.sv | 12 +
 rtl/mips_regfile_clear_seq.sv | 48 ++++
 rtl/mips_regfile.sv | 95 +++++++++
 tb/tb_mips_regfile.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared types and default widths for the mips register file
package mips_pkg;

  localparam int MIPS_REG_ADDR_W = 3;
  localparam int MIPS_REG_DATA_W = 8;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_e;

endpackage

// File: rtl/mips_regfile_clear_seq.sv
// rtl/mips_regfile_clear_seq.sv - clear sequencer: zeroes one register per cycle
module mips_regfile_clear_seq
  import mips_pkg::*;
#(
  parameter int ADDR_W = MIPS_REG_ADDR_W
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_clear,
  output logic              o_busy,
  output logic              o_clr_we,
  output logic [ADDR_W-1:0] o_clr_addr
);

  state_e            r_state;
  logic [ADDR_W-1:0] r_ptr;

  // Reset or a clear request (only honoured when idle) restarts the sweep at
  // entry 0; the sweep ends on the edge that clears the last entry.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= ST_CLEAR;
      r_ptr   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (i_clear) begin
            r_state <= ST_CLEAR;
            r_ptr   <= '0;
          end
        end
        ST_CLEAR: begin
          r_ptr <= r_ptr + 1'b1;
          if (r_ptr == {ADDR_W{1'b1}}) begin
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // The reset edge itself must not modify storage, so the strobe is gated by rst.
  assign o_busy     = (r_state == ST_CLEAR);
  assign o_clr_we   = o_busy & ~i_rst;
  assign o_clr_addr = r_ptr;

endmodule

// File: rtl/mips_regfile.sv
// rtl/mips_regfile.sv - parametrised register file with forwarding, clear engine and debug port
module mips_regfile
  import mips_pkg::*;
#(
  parameter int ADDR_W   = MIPS_REG_ADDR_W,
  parameter int DATA_W   = MIPS_REG_DATA_W,
  parameter int ZERO_REG = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              RegWrite,
  input  logic [ADDR_W-1:0] WriteAddr,
  input  logic [DATA_W-1:0] WriteData,
  input  logic [ADDR_W-1:0] ReadAddr1,
  input  logic [ADDR_W-1:0] ReadAddr2,
  output logic [DATA_W-1:0] ReadData1,
  output logic [DATA_W-1:0] ReadData2,
  input  logic              clear,
  output logic              busy,
  output logic              WriteDrop,
  input  logic [ADDR_W-1:0] DbgAddr,
  output logic [DATA_W-1:0] DbgData
);

  localparam int NUM_REGS = 2 ** ADDR_W;

  logic [DATA_W-1:0] r_regs [NUM_REGS];
  logic              r_drop;
  logic [DATA_W-1:0] r_dbg;

  logic              w_busy;
  logic              w_clr_we;
  logic [ADDR_W-1:0] w_clr_addr;
  logic              w_zero_wr;
  logic              w_wr_ok;

  mips_regfile_clear_seq #(
    .ADDR_W(ADDR_W)
  ) u_clear_seq (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_clear    (clear),
    .o_busy     (w_busy),
    .o_clr_we   (w_clr_we),
    .o_clr_addr (w_clr_addr)
  );

  assign w_zero_wr = (ZERO_REG != 0) && (WriteAddr == '0);
  assign w_wr_ok   = RegWrite & ~w_busy & ~w_zero_wr;

  // Storage: the clear sweep and writeback are mutually exclusive through busy.
  always_ff @(posedge clk) begin
    if (w_clr_we) begin
      r_regs[w_clr_addr] <= '0;
    end else if (w_wr_ok) begin
      r_regs[WriteAddr] <= WriteData;
    end
  end

  // Discarded-write flag and unforwarded debug snapshot, both one cycle late.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_drop <= 1'b0;
      r_dbg  <= '0;
    end else begin
      r_drop <= RegWrite & (w_busy | w_zero_wr);
      r_dbg  <= r_regs[DbgAddr];
    end
  end

  // Read port 1: busy mask, then hardwired zero, then forwarding, then storage.
  always_comb begin
    ReadData1 = r_regs[ReadAddr1];
    if (w_busy || ((ZERO_REG != 0) && (ReadAddr1 == '0))) begin
      ReadData1 = '0;
    end else if (w_wr_ok && (WriteAddr == ReadAddr1)) begin
      ReadData1 = WriteData;
    end
  end

  // Read port 2: same priority as port 1.
  always_comb begin
    ReadData2 = r_regs[ReadAddr2];
    if (w_busy || ((ZERO_REG != 0) && (ReadAddr2 == '0))) begin
      ReadData2 = '0;
    end else if (w_wr_ok && (WriteAddr == ReadAddr2)) begin
      ReadData2 = WriteData;
    end
  end

  assign busy      = w_busy;
  assign WriteDrop = r_drop;
  assign DbgData   = r_dbg;

endmodule

// File: tb/tb_mips_regfile.sv
// tb/tb_mips_regfile.sv - directed self-checking bench for mips_regfile
module tb_mips_regfile;

  localparam int AW = 3;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          RegWrite;
  logic [AW-1:0] WriteAddr;
  logic [DW-1:0] WriteData;
  logic [AW-1:0] ReadAddr1;
  logic [AW-1:0] ReadAddr2;
  logic          clear;
  logic [AW-1:0] DbgAddr;

  logic [DW-1:0] rd1, rd2, dbg;
  logic          bsy, drop;
  logic [DW-1:0] z_rd1, z_rd2, z_dbg;
  logic          z_bsy, z_drop;

  always #5 clk = ~clk;

  mips_regfile #(.ADDR_W(AW), .DATA_W(DW), .ZERO_REG(0)) dut (
    .clk(clk), .rst(rst), .RegWrite(RegWrite), .WriteAddr(WriteAddr),
    .WriteData(WriteData), .ReadAddr1(ReadAddr1), .ReadAddr2(ReadAddr2),
    .ReadData1(rd1), .ReadData2(rd2), .clear(clear), .busy(bsy),
    .WriteDrop(drop), .DbgAddr(DbgAddr), .DbgData(dbg)
  );

  mips_regfile #(.ADDR_W(AW), .DATA_W(DW), .ZERO_REG(1)) dut_z (
    .clk(clk), .rst(rst), .RegWrite(RegWrite), .WriteAddr(WriteAddr),
    .WriteData(WriteData), .ReadAddr1(ReadAddr1), .ReadAddr2(ReadAddr2),
    .ReadData1(z_rd1), .ReadData2(z_rd2), .clear(clear), .busy(z_bsy),
    .WriteDrop(z_drop), .DbgAddr(DbgAddr), .DbgData(z_dbg)
  );

  typedef struct {
    logic          we;
    logic [AW-1:0] wa;
    logic [DW-1:0] wd;
    logic [AW-1:0] a1;
    logic [AW-1:0] a2;
    logic [DW-1:0] e1;
    logic [DW-1:0] e2;
    logic          ed;
    logic [DW-1:0] z1;
    logic [DW-1:0] z2;
    logic          zd;
  } vec_t;

  vec_t vecs [8];

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Advance one rising edge and settle 1ns past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    vecs[0] = '{1'b1, 3'd3, 8'hA5, 3'd3, 3'd4, 8'hA5, 8'h00, 1'b0, 8'hA5, 8'h00, 1'b0};
    vecs[1] = '{1'b0, 3'd0, 8'h00, 3'd3, 3'd4, 8'hA5, 8'h00, 1'b0, 8'hA5, 8'h00, 1'b0};
    vecs[2] = '{1'b1, 3'd4, 8'h5A, 3'd4, 3'd3, 8'h5A, 8'hA5, 1'b0, 8'h5A, 8'hA5, 1'b0};
    vecs[3] = '{1'b1, 3'd7, 8'hFF, 3'd7, 3'd7, 8'hFF, 8'hFF, 1'b0, 8'hFF, 8'hFF, 1'b0};
    vecs[4] = '{1'b0, 3'd0, 8'h00, 3'd7, 3'd4, 8'hFF, 8'h5A, 1'b0, 8'hFF, 8'h5A, 1'b0};
    vecs[5] = '{1'b1, 3'd3, 8'h01, 3'd3, 3'd0, 8'h01, 8'h00, 1'b0, 8'h01, 8'h00, 1'b0};
    vecs[6] = '{1'b1, 3'd0, 8'hC3, 3'd0, 3'd3, 8'hC3, 8'h01, 1'b0, 8'h00, 8'h01, 1'b1};
    vecs[7] = '{1'b0, 3'd0, 8'h00, 3'd0, 3'd1, 8'hC3, 8'h00, 1'b0, 8'h00, 8'h00, 1'b0};

    rst = 1'b1; RegWrite = 1'b0; WriteAddr = '0; WriteData = '0;
    ReadAddr1 = '0; ReadAddr2 = '0; clear = 1'b0; DbgAddr = '0;

    // Reset release: busy for exactly 8 edges, reads masked throughout.
    tick();
    chk("rst_busy", bsy, 1);
    chk("rst_drop", drop, 0);
    chk("rst_dbg", dbg, 0);
    chk("rst_rd1", rd1, 0);
    rst = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      ReadAddr1 = AW'(k - 1);
      ReadAddr2 = AW'(8 - k);
      #1;
      chk("init_rd1_masked", rd1, 0);
      chk("init_rd2_masked", rd2, 0);
      tick();
      chk("init_busy", bsy, (k < 8) ? 1 : 0);
      chk("init_busy_z", z_bsy, (k < 8) ? 1 : 0);
    end
    for (int i = 0; i < 8; i++) begin
      ReadAddr1 = AW'(i);
      #1;
      chk("init_zeroed", rd1, 0);
    end

    // Table-driven writes/reads with forwarding on both DUT variants.
    for (int i = 0; i < 8; i++) begin
      RegWrite = vecs[i].we; WriteAddr = vecs[i].wa; WriteData = vecs[i].wd;
      ReadAddr1 = vecs[i].a1; ReadAddr2 = vecs[i].a2;
      #1;
      chk("vec_rd1", rd1, vecs[i].e1);
      chk("vec_rd2", rd2, vecs[i].e2);
      chk("vec_z_rd1", z_rd1, vecs[i].z1);
      chk("vec_z_rd2", z_rd2, vecs[i].z2);
      tick();
      chk("vec_drop", drop, vecs[i].ed);
      chk("vec_z_drop", z_drop, vecs[i].zd);
    end
    RegWrite = 1'b0;
    ReadAddr1 = 3'd0;
    #1;
    chk("zero_after_rd1", z_rd1, 0);

    // Clear request with loaded registers; write to reg 7 coincides with clear.
    for (int i = 1; i <= 6; i++) begin
      RegWrite = 1'b1; WriteAddr = AW'(i); WriteData = DW'(i * 8'h11);
      tick();
    end
    DbgAddr = 3'd5;
    RegWrite = 1'b1; WriteAddr = 3'd7; WriteData = 8'h77; ReadAddr1 = 3'd7; clear = 1'b1;
    #1;
    chk("clr_fwd", rd1, 8'h77);
    tick();
    RegWrite = 1'b0; clear = 1'b0;
    chk("clr_busy0", bsy, 1);
    chk("clr_drop0", drop, 0);
    chk("clr_dbg0", dbg, 8'h55);
    for (int k = 1; k <= 8; k++) begin
      if (k == 2) begin
        RegWrite = 1'b1; WriteAddr = 3'd2; WriteData = 8'h3C; ReadAddr1 = 3'd2;
        #1;
        chk("clr_rd_masked", rd1, 0);
      end
      tick();
      RegWrite = 1'b0;
      chk("clr_dbg", dbg, (k <= 6) ? 8'h55 : 8'h00);
      chk("clr_busy", bsy, (k < 8) ? 1 : 0);
      chk("clr_drop", drop, (k == 2) ? 1 : 0);
      chk("clr_z_drop", z_drop, (k == 2) ? 1 : 0);
    end
    ReadAddr1 = 3'd2; ReadAddr2 = 3'd7;
    #1;
    chk("clr_reg2", rd1, 0);
    chk("clr_reg7", rd2, 0);

    // Reset asserted in the 4th busy cycle restarts the full sweep.
    clear = 1'b1;
    tick();
    clear = 1'b0;
    tick(); tick(); tick();
    chk("mid_busy", bsy, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rst_busy", bsy, 1);
    chk("mid_rst_dbg", dbg, 0);
    for (int k = 1; k <= 8; k++) begin
      tick();
      chk("mid_busy_run", bsy, (k < 8) ? 1 : 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
